// File: rtl/snake_head_ctrl.sv
// Snake head controller: move-tick timing, direction latching and head/prev cell tracking.
// Emits the body-segment move strobe and ends the game on a wall hit or body collision.
module snake_head_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 32,
    parameter int START_X  = 16,
    parameter int START_Y  = 16,
    parameter int WRAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision_in,
    output logic [4:0] snake_head_x,
    output logic [4:0] snake_head_y,
    output logic [4:0] head_prev_x,
    output logic [4:0] head_prev_y,
    output logic       enable,
    output logic       game_over,
    output logic       running
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]      X_MAX   = 5'(GRID_W - 1);
    localparam logic [4:0]      Y_MAX   = 5'(GRID_H - 1);
    localparam logic [4:0]      X0      = 5'(START_X);
    localparam logic [4:0]      Y0      = 5'(START_Y);
    localparam logic [4:0]      PX0     = 5'(START_X - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t           state, state_nxt;
    dir_t             dir, pend_dir, pend_nxt, req_dir;
    logic             req_vld;
    logic [CNT_W-1:0] cnt;
    logic             enable_d;
    logic             tick, col_hit, wall, move_ok;
    logic [4:0]       nxt_x, nxt_y;

    function automatic logic is_reverse(input dir_t a, input dir_t b);
        case (a)
            DIR_UP:    is_reverse = (b == DIR_DOWN);
            DIR_DOWN:  is_reverse = (b == DIR_UP);
            DIR_LEFT:  is_reverse = (b == DIR_RIGHT);
            default:   is_reverse = (b == DIR_LEFT);
        endcase
    endfunction

    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_RIGHT;
        if (btn_up)         req_dir = DIR_UP;
        else if (btn_down)  req_dir = DIR_DOWN;
        else if (btn_left)  req_dir = DIR_LEFT;
        else if (btn_right) req_dir = DIR_RIGHT;
        else                req_vld = 1'b0;
    end

    // A request made in the tick cycle itself still steers that tick's move.
    assign pend_nxt = (state == RUN && req_vld && !is_reverse(req_dir, dir)) ? req_dir : pend_dir;
    assign tick     = (state == RUN) && (cnt == CNT_MAX);
    assign col_hit  = (state == RUN) && enable_d && collision_in;

    always_comb begin
        nxt_x = snake_head_x;
        nxt_y = snake_head_y;
        wall  = 1'b0;
        case (pend_nxt)
            DIR_RIGHT: begin
                if (snake_head_x == X_MAX) begin nxt_x = 5'd0;  wall = (WRAP == 0); end
                else                              nxt_x = snake_head_x + 5'd1;
            end
            DIR_LEFT: begin
                if (snake_head_x == 5'd0) begin nxt_x = X_MAX; wall = (WRAP == 0); end
                else                             nxt_x = snake_head_x - 5'd1;
            end
            DIR_DOWN: begin
                if (snake_head_y == Y_MAX) begin nxt_y = 5'd0;  wall = (WRAP == 0); end
                else                              nxt_y = snake_head_y + 5'd1;
            end
            default: begin
                if (snake_head_y == 5'd0) begin nxt_y = Y_MAX; wall = (WRAP == 0); end
                else                             nxt_y = snake_head_y - 5'd1;
            end
        endcase
    end

    // Collision in the sample cycle pre-empts a coinciding tick.
    assign move_ok = tick && !col_hit && !wall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (col_hit || (tick && wall)) state_nxt = OVER;
            OVER:    if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snake_head_x <= X0;
            snake_head_y <= Y0;
            head_prev_x  <= PX0;
            head_prev_y  <= Y0;
            dir          <= DIR_RIGHT;
            pend_dir     <= DIR_RIGHT;
            cnt          <= '0;
            enable       <= 1'b0;
            enable_d     <= 1'b0;
        end else begin
            enable   <= move_ok;
            enable_d <= enable;
            if (state == IDLE && start) begin
                snake_head_x <= X0;
                snake_head_y <= Y0;
                head_prev_x  <= PX0;
                head_prev_y  <= Y0;
                dir          <= DIR_RIGHT;
                pend_dir     <= DIR_RIGHT;
                cnt          <= '0;
            end else if (state == RUN) begin
                pend_dir <= pend_nxt;
                if (!col_hit) begin
                    cnt <= tick ? '0 : cnt + CNT_W'(1);
                    if (tick) dir <= pend_nxt;
                end
                if (move_ok) begin
                    head_prev_x  <= snake_head_x;
                    head_prev_y  <= snake_head_y;
                    snake_head_x <= nxt_x;
                    snake_head_y <= nxt_y;
                end
            end
        end
    end

    assign running   = (state == RUN);
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: a WRAP=1 and a WRAP=0 instance share randomized stimulus and
// are scored against an integer grid model; move results flow through a per-instance queue.
module tb_snake_head_ctrl;

    localparam int TICK = 4;
    localparam int GW   = 32;
    localparam int GH   = 32;
    localparam int SX   = 16;
    localparam int SY   = 16;
    localparam int S_IDLE = 0, S_RUN = 1, S_OVER = 2;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic collision_in = 1'b0;
    logic [4:0] hx [2];
    logic [4:0] hy [2];
    logic [4:0] px [2];
    logic [4:0] py [2];
    logic en [2];
    logic go [2];
    logic run [2];

    int n_pass = 0;
    int n_total = 0;

    typedef struct { int hx; int hy; int px; int py; } mv_t;
    mv_t q0[$];
    mv_t q1[$];

    int m_state[2], m_hx[2], m_hy[2], m_px[2], m_py[2], m_dir[2], m_pend[2], m_cnt[2];
    bit m_en[2], m_samp[2];

    always #5 clk = ~clk;

    snake_head_ctrl #(.TICK_DIV(TICK), .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .collision_in(collision_in),
        .snake_head_x(hx[0]), .snake_head_y(hy[0]), .head_prev_x(px[0]), .head_prev_y(py[0]),
        .enable(en[0]), .game_over(go[0]), .running(run[0]));

    snake_head_ctrl #(.TICK_DIV(TICK), .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY), .WRAP(0)) u_wall (
        .clk(clk), .rst_n(rst_n), .start(start), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .collision_in(collision_in),
        .snake_head_x(hx[1]), .snake_head_y(hy[1]), .head_prev_x(px[1]), .head_prev_y(py[1]),
        .enable(en[1]), .game_over(go[1]), .running(run[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int dx(input int d);
        return (d == D_LEFT) ? -1 : (d == D_RIGHT) ? 1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == D_UP) ? -1 : (d == D_DOWN) ? 1 : 0;
    endfunction

    task automatic model_reset(input int d);
        m_state[d] = S_IDLE;
        m_hx[d] = SX; m_hy[d] = SY; m_px[d] = SX - 1; m_py[d] = SY;
        m_dir[d] = D_RIGHT; m_pend[d] = D_RIGHT; m_cnt[d] = 0;
        m_en[d] = 0; m_samp[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    // One clock edge of the game rules, applied to the inputs currently driven.
    task automatic model_step(input int d, input int wrap);
        bit was_en;
        int req, nx, ny;
        mv_t mv;
        if (!rst_n) begin model_reset(d); return; end
        was_en = m_en[d];
        m_en[d] = 0;
        case (m_state[d])
            S_IDLE: if (start) begin
                model_reset(d);
                m_state[d] = S_RUN;
            end
            S_RUN: begin
                req = -1;
                if (btn_up) req = D_UP;
                else if (btn_down) req = D_DOWN;
                else if (btn_left) req = D_LEFT;
                else if (btn_right) req = D_RIGHT;
                if (req >= 0 && !(dx(req) == -dx(m_dir[d]) && dy(req) == -dy(m_dir[d])))
                    m_pend[d] = req;
                if (m_samp[d] && collision_in) begin
                    m_state[d] = S_OVER;
                end else if (m_cnt[d] == TICK - 1) begin
                    m_cnt[d] = 0;
                    m_dir[d] = m_pend[d];
                    nx = m_hx[d] + dx(m_dir[d]);
                    ny = m_hy[d] + dy(m_dir[d]);
                    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                        if (wrap != 0) begin nx = (nx + GW) % GW; ny = (ny + GH) % GH; end
                        else m_state[d] = S_OVER;
                    end
                    if (m_state[d] == S_RUN) begin
                        m_px[d] = m_hx[d]; m_py[d] = m_hy[d];
                        m_hx[d] = nx; m_hy[d] = ny;
                        m_en[d] = 1;
                        mv.hx = nx; mv.hy = ny; mv.px = m_px[d]; mv.py = m_py[d];
                        if (d == 0) q0.push_back(mv); else q1.push_back(mv);
                    end
                end else begin
                    m_cnt[d]++;
                end
            end
            default: if (start) m_state[d] = S_IDLE;
        endcase
        m_samp[d] = was_en;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("head_x[%0d]", d), hx[d], m_hx[d]);
            chk($sformatf("head_y[%0d]", d), hy[d], m_hy[d]);
            chk($sformatf("prev_x[%0d]", d), px[d], m_px[d]);
            chk($sformatf("prev_y[%0d]", d), py[d], m_py[d]);
            chk($sformatf("enable[%0d]", d), en[d], m_en[d]);
            chk($sformatf("running[%0d]", d), run[d], m_state[d] == S_RUN);
            chk($sformatf("game_over[%0d]", d), go[d], m_state[d] == S_OVER);
        end
    endtask

    task automatic cycle(input bit rn, input bit s, input bit u, input bit dn,
                         input bit l, input bit r, input bit c);
        @(negedge clk);
        compare_all();
        #1;
        rst_n = rn; start = s; btn_up = u; btn_down = dn; btn_left = l; btn_right = r;
        collision_in = c;
        model_step(0, 1);
        model_step(1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor: every enable strobe must match the oldest predicted move.
    always @(negedge clk) begin
        mv_t mv;
        if (rst_n) begin
            if (en[0]) begin
                if (q0.size() == 0) chk("unexpected_enable[0]", 1, 0);
                else begin
                    mv = q0.pop_front();
                    chk("sb_head_x[0]", hx[0], mv.hx); chk("sb_head_y[0]", hy[0], mv.hy);
                    chk("sb_prev_x[0]", px[0], mv.px); chk("sb_prev_y[0]", py[0], mv.py);
                end
            end
            if (en[1]) begin
                if (q1.size() == 0) chk("unexpected_enable[1]", 1, 0);
                else begin
                    mv = q1.pop_front();
                    chk("sb_head_x[1]", hx[1], mv.hx); chk("sb_head_y[1]", hy[1], mv.hy);
                    chk("sb_prev_x[1]", px[1], mv.px); chk("sb_prev_y[1]", py[1], mv.py);
                end
            end
        end
    end

    initial begin
        bit found;
        model_reset(0);
        model_reset(1);

        // Reset, then start on the very first clock after deassertion; run straight right.
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        idle(72);
        chk("wrap_running", run[0], 1);
        chk("wall_game_over", go[1], 1);
        chk("wall_head_x", hx[1], 31);
        chk("wall_head_y", hy[1], 16);

        // Reverse request discarded, up beats down in the same cycle.
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 1, 1, 0, 0, 0);
        idle(3);
        chk("turn_head_x", hx[0], 16);
        chk("turn_head_y", hy[0], 15);
        chk("turn_prev_y", py[0], 16);

        // Collision high everywhere except where it counts is ignored; then hit the sample cycle.
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1, 0, 0, 0, 0, 0, 1);
            found = m_en[0];
        end
        if (!found) chk("wait_enable_timeout", 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        idle(8);
        chk("collision_game_over", go[0], 1);
        chk("collision_head_x", hx[0], 17);

        // Start in OVER returns to IDLE; a second start re-runs from the start cell.
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("over_to_idle_run", run[0], 0);
        chk("over_to_idle_go", go[0], 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rerun_running", run[0], 1);
        chk("rerun_head_x", hx[0], 16);

        // Asynchronous reset in the middle of an enable cycle.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            found = m_en[0];
        end
        if (!found) chk("wait_enable_timeout2", 0, 1);
        @(negedge clk);
        compare_all();
        #2 rst_n = 1'b0;
        #1;
        chk("async_enable", en[0], 0);
        chk("async_head_x", hx[0], 16);
        chk("async_head_y", hy[0], 16);
        chk("async_prev_x", px[0], 15);
        chk("async_running", run[0], 0);
        chk("async_game_over", go[0], 0);
        model_reset(0);
        model_reset(1);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Randomized play with occasional resets and restarts.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 399) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
